// File: rtl/arithmetic_logic_if.sv
// ALU operand/strobe/result bundle between instruction decode and the ALU.
// The master (decode) drives the op strobes and the operands. The slave
// (the ALU) returns the result and the status flags.
interface arithmetic_logic_if;
  // ALU op strobes (one-hot from decode)
  logic       add;
  logic       sub;
  logic       amp;
  logic       lor;
  logic       flp;
  logic       eor;
  logic       lsx;
  logic       lsy;
  // Parity / compare strobes
  logic       prc0;
  logic       prc1;
  logic       prc2;
  logic       prc4;
  logic       prc8;
  logic       prgl;
  logic       prgh;
  logic       eql;
  // Operands
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] m;
  // Results
  logic [7:0] res;
  logic       cf;
  logic       zf;

  modport master (
    output add, sub, amp, lor, flp, eor, lsx, lsy,
    output prc0, prc1, prc2, prc4, prc8, prgl, prgh, eql,
    output x, y, m,
    input  res, cf, zf
  );

  modport slave (
    input  add, sub, amp, lor, flp, eor, lsx, lsy,
    input  prc0, prc1, prc2, prc4, prc8, prgl, prgh, eql,
    input  x, y, m,
    output res, cf, zf
  );
endinterface

// File: rtl/arithmetic_logic.sv
// 8-bit ALU datapath of the 9-bit CPU.
// The result is combinational and selected by prioritised op strobes.
// The Hamming(16,11) encoder serves the ECC programs.
// The carry and zero status flags are registered for later branches.
module arithmetic_logic (
  input  logic                 clk,
  input  logic                 rst_n,
  arithmetic_logic_if.slave    bus
);

  // Extended Hamming(16,11) encoder.
  // Data bits occupy the non-power-of-two positions.
  // Bit 0 is the overall parity over bits 15..1.
  function automatic logic [15:0] hamming_encode(input logic [10:0] d);
    logic [15:0] c;
    c       = 16'h0000;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    c[1]    = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]    = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]    = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]    = ^c[15:9];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  logic [8:0]  sum_s;
  logic [8:0]  diff_s;
  logic [7:0]  shl_s;
  logic [7:0]  shr_s;
  logic [15:0] code_s;
  logic        any_s;
  logic [7:0]  res_s;
  logic        carry_s;
  logic        cf_r;
  logic        zf_r;

  // Shared arithmetic, shift and encoder terms.
  // A shift amount of 8 or more pushes every bit out of the 8-bit result.
  // Bit 8 of the difference is the borrow.
  always_comb begin
    sum_s  = {1'b0, bus.x} + {1'b0, bus.y};
    diff_s = {1'b0, bus.x} - {1'b0, bus.y};
    shl_s  = bus.x << bus.y[3:0];
    shr_s  = bus.x >> bus.y[3:0];
    code_s = hamming_encode({bus.y[2:0], bus.x});
    any_s  = bus.add  | bus.sub  | bus.amp  | bus.lor  |
             bus.flp  | bus.eor  | bus.lsx  | bus.lsy  |
             bus.prc0 | bus.prc1 | bus.prc2 | bus.prc4 |
             bus.prc8 | bus.prgl | bus.prgh | bus.eql;
  end

  // Prioritised result select. Only add and sub produce a carry.
  always_comb begin
    res_s   = 8'h00;
    carry_s = 1'b0;
    if (bus.add) begin
      res_s   = sum_s[7:0];
      carry_s = sum_s[8];
    end else if (bus.sub) begin
      res_s   = diff_s[7:0];
      carry_s = diff_s[8];
    end else if (bus.amp) begin
      res_s = bus.x & bus.y;
    end else if (bus.lor) begin
      res_s = bus.x | bus.y;
    end else if (bus.flp) begin
      res_s = bus.x ^ bus.m;
    end else if (bus.eor) begin
      res_s = bus.x ^ bus.y;
    end else if (bus.lsx) begin
      res_s = shl_s;
    end else if (bus.lsy) begin
      res_s = shr_s;
    end else if (bus.prc0) begin
      res_s = {7'b0000000, code_s[0]};
    end else if (bus.prc1) begin
      res_s = {7'b0000000, code_s[1]};
    end else if (bus.prc2) begin
      res_s = {7'b0000000, code_s[2]};
    end else if (bus.prc4) begin
      res_s = {7'b0000000, code_s[4]};
    end else if (bus.prc8) begin
      res_s = {7'b0000000, code_s[8]};
    end else if (bus.prgl) begin
      res_s = code_s[7:0];
    end else if (bus.prgh) begin
      res_s = code_s[15:8];
    end else if (bus.eql) begin
      res_s = {7'b0000000, (bus.x == bus.y)};
    end else begin
      res_s   = 8'h00;
      carry_s = 1'b0;
    end
  end

  // Status flags. They update only on cycles with an active op and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_r <= 1'b0;
      zf_r <= 1'b0;
    end else if (any_s) begin
      cf_r <= carry_s;
      zf_r <= (res_s == 8'h00);
    end else begin
      cf_r <= cf_r;
      zf_r <= zf_r;
    end
  end

  assign bus.res = res_s;
  assign bus.cf  = cf_r;
  assign bus.zf  = zf_r;

endmodule

// File: tb/tb_arithmetic_logic.sv
// Directed-vector bench for arithmetic_logic.
// Each scenario task drives operands on the falling edge.
// It checks res 1 ns later and checks the flags 1 ns after the rising edge.
module tb_arithmetic_logic;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  arithmetic_logic_if ifc ();

  arithmetic_logic dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_strobes();
    ifc.add = 1'b0; ifc.sub = 1'b0; ifc.amp = 1'b0; ifc.lor = 1'b0;
    ifc.flp = 1'b0; ifc.eor = 1'b0; ifc.lsx = 1'b0; ifc.lsy = 1'b0;
    ifc.prc0 = 1'b0; ifc.prc1 = 1'b0; ifc.prc2 = 1'b0; ifc.prc4 = 1'b0;
    ifc.prc8 = 1'b0; ifc.prgl = 1'b0; ifc.prgh = 1'b0; ifc.eql = 1'b0;
  endtask

  task automatic operands(input logic [7:0] a, input logic [7:0] b, input logic [7:0] k);
    @(negedge clk);
    clear_strobes();
    ifc.x = a; ifc.y = b; ifc.m = k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_strobes();
    ifc.x = 8'h00; ifc.y = 8'h00; ifc.m = 8'h00;
    #3;
    vectors++; if (ifc.cf !== 1'b0) begin $display("FAIL reset_cf got %b exp 0", ifc.cf); miscompares++; end
    vectors++; if (ifc.zf !== 1'b0) begin $display("FAIL reset_zf got %b exp 0", ifc.zf); miscompares++; end
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL reset_res got %h exp 00", ifc.res); miscompares++; end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    operands(8'd1, 8'd1, 8'd0); ifc.add = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd2) begin $display("FAIL add_1_1 got %0d exp 2", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b0 || ifc.zf !== 1'b0) begin $display("FAIL add_1_1_flags got cf=%b zf=%b exp 0 0", ifc.cf, ifc.zf); miscompares++; end
    operands(8'd13, 8'd12, 8'd0); ifc.add = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd25) begin $display("FAIL add_13_12 got %0d exp 25", ifc.res); miscompares++; end
    operands(8'd165, 8'd255, 8'd0); ifc.add = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd164) begin $display("FAIL add_wrap got %0d exp 164", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1 || ifc.zf !== 1'b0) begin $display("FAIL add_carry_flags got cf=%b zf=%b exp 1 0", ifc.cf, ifc.zf); miscompares++; end
  endtask

  task automatic test_sub();
    operands(8'd77, 8'd27, 8'd0); ifc.sub = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd50) begin $display("FAIL sub_77_27 got %0d exp 50", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b0) begin $display("FAIL sub_noborrow_cf got %b exp 0", ifc.cf); miscompares++; end
    operands(8'd0, 8'd1, 8'd0); ifc.sub = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd255) begin $display("FAIL sub_0_1 got %0d exp 255", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1) begin $display("FAIL sub_borrow_cf got %b exp 1", ifc.cf); miscompares++; end
    operands(8'd5, 8'd5, 8'd0); ifc.sub = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd0) begin $display("FAIL sub_equal got %0d exp 0", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b0 || ifc.zf !== 1'b1) begin $display("FAIL sub_zero_flags got cf=%b zf=%b exp 0 1", ifc.cf, ifc.zf); miscompares++; end
  endtask

  task automatic test_logic();
    // Set the carry first, then show that a logic op clears it.
    operands(8'd165, 8'd255, 8'd0); ifc.add = 1'b1;
    @(posedge clk);
    operands(8'hFC, 8'h3F, 8'h00); ifc.amp = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h3C) begin $display("FAIL amp got %h exp 3c", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b0 || ifc.zf !== 1'b0) begin $display("FAIL amp_flags got cf=%b zf=%b exp 0 0", ifc.cf, ifc.zf); miscompares++; end
    operands(8'hA0, 8'h05, 8'h00); ifc.lor = 1'b1; #1;
    vectors++; if (ifc.res !== 8'hA5) begin $display("FAIL lor got %h exp a5", ifc.res); miscompares++; end
    operands(8'hFF, 8'h0F, 8'h00); ifc.eor = 1'b1; #1;
    vectors++; if (ifc.res !== 8'hF0) begin $display("FAIL eor got %h exp f0", ifc.res); miscompares++; end
    operands(8'h55, 8'hFF, 8'h0F); ifc.flp = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h5A) begin $display("FAIL flp got %h exp 5a", ifc.res); miscompares++; end
  endtask

  task automatic test_shift();
    operands(8'h01, 8'd9, 8'h00); ifc.lsx = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL lsx_by9 got %h exp 00", ifc.res); miscompares++; end
    operands(8'h81, 8'd1, 8'h00); ifc.lsx = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h02) begin $display("FAIL lsx_by1 got %h exp 02", ifc.res); miscompares++; end
    operands(8'h03, 8'h12, 8'h00); ifc.lsx = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h0C) begin $display("FAIL lsx_upper_ignored got %h exp 0c", ifc.res); miscompares++; end
    operands(8'h80, 8'd7, 8'h00); ifc.lsy = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL lsy_by7 got %h exp 01", ifc.res); miscompares++; end
    operands(8'hFF, 8'd8, 8'h00); ifc.lsy = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL lsy_by8 got %h exp 00", ifc.res); miscompares++; end
  endtask

  task automatic test_parity();
    // The all-ones message encodes to the all-ones codeword.
    // Each parity group covers seven ones, and bit 0 covers fifteen.
    operands(8'hFF, 8'h07, 8'h00); ifc.prgl = 1'b1; #1;
    vectors++; if (ifc.res !== 8'hFF) begin $display("FAIL prgl_ones got %h exp ff", ifc.res); miscompares++; end
    operands(8'hFF, 8'h07, 8'h00); ifc.prgh = 1'b1; #1;
    vectors++; if (ifc.res !== 8'hFF) begin $display("FAIL prgh_ones got %h exp ff", ifc.res); miscompares++; end
    operands(8'hFF, 8'h07, 8'h00); ifc.prc0 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL prc0_ones got %h exp 01", ifc.res); miscompares++; end
    // With only d0 set, c3=1 drives p1 and p2. Then p0 = c1^c2^c3 = 1.
    operands(8'h01, 8'h00, 8'h00); ifc.prgl = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h0F) begin $display("FAIL prgl_d0 got %h exp 0f", ifc.res); miscompares++; end
    operands(8'h01, 8'h00, 8'h00); ifc.prc4 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL prc4_d0 got %h exp 00", ifc.res); miscompares++; end
    operands(8'h01, 8'h00, 8'h00); ifc.prc2 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL prc2_d0 got %h exp 01", ifc.res); miscompares++; end
    // With only d4 set, c9=1 drives p1 and p8. Then p0 = 1.
    operands(8'h10, 8'h00, 8'h00); ifc.prgl = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h03) begin $display("FAIL prgl_d4 got %h exp 03", ifc.res); miscompares++; end
    operands(8'h10, 8'h00, 8'h00); ifc.prgh = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h03) begin $display("FAIL prgh_d4 got %h exp 03", ifc.res); miscompares++; end
    operands(8'h10, 8'h00, 8'h00); ifc.prc8 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL prc8_d4 got %h exp 01", ifc.res); miscompares++; end
    // With only d10 set, c15=1 drives every parity. y[7:3] must be ignored.
    operands(8'h00, 8'hFC, 8'h00); ifc.prgl = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h17) begin $display("FAIL prgl_d10 got %h exp 17", ifc.res); miscompares++; end
    operands(8'h00, 8'hFC, 8'h00); ifc.prgh = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h81) begin $display("FAIL prgh_d10 got %h exp 81", ifc.res); miscompares++; end
    operands(8'h00, 8'hFC, 8'h00); ifc.prc1 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL prc1_d10 got %h exp 01", ifc.res); miscompares++; end
  endtask

  task automatic test_compare();
    operands(8'd5, 8'd5, 8'h00); ifc.eql = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h01) begin $display("FAIL eql_same got %h exp 01", ifc.res); miscompares++; end
    operands(8'd5, 8'd6, 8'h00); ifc.eql = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL eql_diff got %h exp 00", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.zf !== 1'b1 || ifc.cf !== 1'b0) begin $display("FAIL eql_flags got cf=%b zf=%b exp 0 1", ifc.cf, ifc.zf); miscompares++; end
  endtask

  task automatic test_priority();
    operands(8'd10, 8'd3, 8'h00); ifc.add = 1'b1; ifc.sub = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd13) begin $display("FAIL prio_add_sub got %0d exp 13", ifc.res); miscompares++; end
    operands(8'd10, 8'd3, 8'h00); ifc.sub = 1'b1; ifc.amp = 1'b1; ifc.eql = 1'b1; #1;
    vectors++; if (ifc.res !== 8'd7) begin $display("FAIL prio_sub_amp got %0d exp 7", ifc.res); miscompares++; end
    operands(8'hF0, 8'h0F, 8'h00); ifc.eor = 1'b1; ifc.lsx = 1'b1; ifc.prc0 = 1'b1; #1;
    vectors++; if (ifc.res !== 8'hFF) begin $display("FAIL prio_eor_lsx got %h exp ff", ifc.res); miscompares++; end
    operands(8'h00, 8'h00, 8'h00); ifc.prgh = 1'b1; ifc.eql = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL prio_prgh_eql got %h exp 00", ifc.res); miscompares++; end
  endtask

  task automatic test_flag_hold();
    operands(8'd0, 8'd1, 8'h00); ifc.sub = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1 || ifc.zf !== 1'b0) begin $display("FAIL hold_setup got cf=%b zf=%b exp 1 0", ifc.cf, ifc.zf); miscompares++; end
    operands(8'd0, 8'd1, 8'h00); #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL no_strobe_res got %h exp 00", ifc.res); miscompares++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1 || ifc.zf !== 1'b0) begin $display("FAIL hold_flags got cf=%b zf=%b exp 1 0", ifc.cf, ifc.zf); miscompares++; end
  endtask

  task automatic test_async_reset();
    operands(8'd128, 8'd128, 8'h00); ifc.add = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h00) begin $display("FAIL add_128_128 got %h exp 00", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1 || ifc.zf !== 1'b1) begin $display("FAIL pre_reset_flags got cf=%b zf=%b exp 1 1", ifc.cf, ifc.zf); miscompares++; end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    vectors++; if (ifc.cf !== 1'b0 || ifc.zf !== 1'b0) begin $display("FAIL async_reset_flags got cf=%b zf=%b exp 0 0", ifc.cf, ifc.zf); miscompares++; end
    clear_strobes(); ifc.x = 8'hFC; ifc.y = 8'h3F; ifc.amp = 1'b1; #1;
    vectors++; if (ifc.res !== 8'h3C) begin $display("FAIL res_in_reset got %h exp 3c", ifc.res); miscompares++; end
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b0 || ifc.zf !== 1'b0) begin $display("FAIL reset_held_flags got cf=%b zf=%b exp 0 0", ifc.cf, ifc.zf); miscompares++; end
    operands(8'd128, 8'd128, 8'h00); ifc.add = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ifc.cf !== 1'b1 || ifc.zf !== 1'b1) begin $display("FAIL post_release_flags got cf=%b zf=%b exp 1 1", ifc.cf, ifc.zf); miscompares++; end
    @(negedge clk); clear_strobes();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_parity();
    test_compare();
    test_priority();
    test_flag_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
